imem_fetch_sequencer: RTL

IMEM_FETCH_SEQUENCER -- requirements
Module: imem_fetch_sequencer

---
 rtl/imem_fetch_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: walks word indices from a start/redirect PC,
// one outstanding read at a time, presenting each word with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start or redirect
// REQ   | issue read at pc (or halt when pc is out of bounds)
// RESP  | read data returning this cycle
// HOLD  | instruction presented, waiting for inst_ready
// HALT  | halt word or end of memory reached, waits for redirect
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_SIZE  = 1024,
  parameter logic [31:0] HALT_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic        busy,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    inst_data_d   = inst_data_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = (pc_q < MEM_LIMIT) ? S_RESP : S_HALT;
      end
      S_RESP: begin
        if (mem_rdata == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          inst_data_d  = mem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          inst_valid_d  = 1'b0;
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides everything except a handshake already completing in HOLD.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      state_d      = S_REQ;
    end

    mem_rd_en_d = (state_d == S_REQ) && (pc_d < MEM_LIMIT);
    busy_d      = (state_d == S_REQ) || (state_d == S_RESP) || (state_d == S_HOLD);
    halted_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
      mem_rd_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
      mem_rd_en_q   <= mem_rd_en_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst_data   = inst_data_q;
  assign inst_pc     = inst_pc_q;
  assign halted      = halted_q;
  assign busy        = busy_q;
  assign fetch_count = fetch_count_q;

endmodule
